fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning bits per FIFO word and per serial frame.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_enable  input  1  permits starting new frames.
REQ-006 SHALL have port i_fifo_data  input  DATA_WIDTH  show-ahead FIFO head word, valid whenever i_fifo_empty is low.
REQ-007 SHALL have port i_fifo_empty  input  1  FIFO empty flag.
REQ-008 SHALL have port o_fifo_read_enable  output  1  single-cycle pop strobe to the FIFO.
REQ-009 SHALL have port o_txd  output  1  serial line, idle high.
REQ-010 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 SHALL drive o_txd: IDLE 1, START 0, DATA shift-register LSB, STOP 1; o_txd SHALL be registered, glitch-free.
REQ-013 SHALL use a baud counter 0..CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT cycles; the counter clears on every state entry.
REQ-014 SHALL assert o_fifo_read_enable combinationally iff i_enable & !i_fifo_empty & (state==IDLE | last cycle of STOP).
REQ-015 SHALL capture i_fifo_data into the shift register in the cycle o_fifo_read_enable is high and enter START on the next edge.
REQ-016 SHALL transmit DATA_WIDTH data bits LSB first, shifting right at each bit boundary, with a 3-bit (clog2 DATA_WIDTH) bit index.
REQ-017 SHALL make one frame exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles: 1 start, DATA_WIDTH data, 1 stop.
REQ-018 SHALL send consecutive frames with zero idle cycles between them when the FIFO is non-empty at the last STOP cycle (REQ-014).
REQ-019 SHALL go STOP->IDLE at the end of stop if no pop occurs; o_txd stays 1.
REQ-020 SHALL complete an in-progress frame when i_enable deasserts mid-frame; only new pops are blocked.
REQ-021 SHALL never assert o_fifo_read_enable while i_fifo_empty is high, nor more than once per frame.
REQ-022 SHALL ignore i_fifo_data changes outside the capture cycle.

Reset
REQ-023 SHALL, on reset_n low, asynchronously force state IDLE, o_txd 1, o_busy 0, counters 0, shift register 0; o_fifo_read_enable SHALL be 0 while reset_n is low.
REQ-024 SHALL abort a frame when reset asserts mid-frame: line high immediately, and no word is re-popped after release unless the FIFO is non-empty.
REQ-025 SHALL allow the first pop no earlier than the first rising edge after reset_n deasserts.

Structure
REQ-026 SHALL place the state encoding (2-bit IDLE=0, START=1, DATA=2, STOP=3) in the shared def include.
REQ-027 SHALL place the default CLKS_PER_BIT and UART frame constants in the shared def include.
REQ-028 SHALL keep the baud counter inline; the one natural sub-module, uart_baud_counter (count plus last-cycle flag), is optional.
REQ-029 SHALL connect directly to the existing fifo read channel (o_data, o_empty, i_read_enable) with no glue logic.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8, bench FIFO model)
REQ-030 SHALL cover single byte: push 0x55 -> one pop; o_txd 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40 cycles total); o_busy high 40 cycles.
REQ-031 SHALL cover back-to-back: push 0xA3, 0x0F -> second pop in cycle 39 of frame 1; frame 2 start bit at cycle 40; no idle-high gap.
REQ-032 SHALL cover empty/disable: i_enable=0 with 0xFF queued -> no pop, o_txd=1; raise i_enable -> pop the next cycle.
REQ-033 SHALL cover mid-frame disable: drop i_enable at cycle 10 of frame 0x81 with a second byte queued -> frame 0x81 completes; no second pop.
REQ-034 SHALL cover reset mid-frame: reset_n low at cycle 17 -> o_txd=1 and o_busy=0 same cycle; after release with FIFO empty, line stays idle.
REQ-035 SHALL run a scoreboard on random bursts of 64 bytes -> deserialized stream equals pushed stream; pop count equals push count.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding,
// default bit timing and serial line levels.
package fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // 100 MHz system clock at 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_DATA_WIDTH   = 8;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a show-ahead FIFO and serializes them
// LSB first as 8N1-style frames, chaining frames with no idle gap.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_read_enable,
  output logic                  o_txd,
  output logic                  o_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  state_t                state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  txd;
  logic                  busy;
  logic                  bit_end;
  logic                  pop_req;

  assign bit_end = (baud_cnt == CNT_LAST);
  assign shifted = shift_reg >> 1;

  // A pop is allowed from IDLE or in the final stop cycle so frames chain back to back.
  assign pop_req = i_enable & ~i_fifo_empty &
                   ((state == IDLE) | ((state == STOP) & bit_end));

  // The state register already reads IDLE during reset; gating keeps the strobe quiet too.
  assign o_fifo_read_enable = pop_req & reset_n;
  assign o_txd              = txd;
  assign o_busy             = busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      txd       <= LINE_IDLE;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop_req) begin
            shift_reg <= i_fifo_data;
            state     <= START;
            txd       <= START_LEVEL;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
              txd   <= STOP_LEVEL;
            end else begin
              // Line follows the LSB of the register after every shift.
              shift_reg <= shifted;
              txd       <= shifted[0];
              bit_idx   <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop_req) begin
              shift_reg <= i_fifo_data;
              state     <= START;
              txd       <= START_LEVEL;
            end else begin
              state <= IDLE;
              txd   <= LINE_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= LINE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at 4 clocks per bit: FIFO model, line deserializer
// feeding a receive log, and a queue of expected bytes.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_enable;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_empty;
  logic          o_fifo_read_enable;
  logic          o_txd;
  logic          o_busy;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_enable           (i_enable),
    .i_fifo_data        (i_fifo_data),
    .i_fifo_empty       (i_fifo_empty),
    .o_fifo_read_enable (o_fifo_read_enable),
    .o_txd              (o_txd),
    .o_busy             (o_busy)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: tasks write, the DUT strobe pops.
  logic [DW-1:0] fifo_mem [256];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            bad_pops = 0;

  assign i_fifo_empty = (wr_ptr == rd_ptr);
  assign i_fifo_data  = fifo_mem[rd_ptr[7:0]];

  always @(posedge clk) begin
    if (o_fifo_read_enable) begin
      if (wr_ptr == rd_ptr) bad_pops <= bad_pops + 1;
      else rd_ptr <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] exp_q [$];
  int            checks = 0;
  int            errors = 0;

  // Line deserializer sampling mid-bit on the falling edge.
  logic [DW-1:0] rx_mem [512];
  bit            rx_ok  [512];
  int            rx_wr = 0;
  int            rx_rd = 0;
  logic          mon_busy = 1'b0;
  logic [5:0]    mon_off = '0;
  logic [DW-1:0] mon_shift = '0;
  logic          mon_start = 1'b1;
  logic          mon_stop = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_busy <= 1'b0;
    end else if (!mon_busy) begin
      if (o_txd === 1'b0) begin
        mon_busy <= 1'b1;
        mon_off  <= 6'd1;
      end
    end else begin
      if (mon_off[1:0] == 2'd2) begin
        if (mon_off[5:2] == 4'd0) mon_start <= o_txd;
        else if (mon_off[5:2] == 4'd9) mon_stop <= o_txd;
        else mon_shift[3'(mon_off[5:2] - 4'd1)] <= o_txd;
      end
      if (mon_off == 6'd39) begin
        rx_mem[rx_wr] <= mon_shift;
        rx_ok[rx_wr]  <= (mon_start === 1'b0) && (mon_stop === 1'b1);
        rx_wr         <= rx_wr + 1;
        mon_busy      <= 1'b0;
      end
      mon_off <= mon_off + 6'd1;
    end
  end

  function automatic logic frame_bit(input logic [DW-1:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j >= DW + 1) return 1'b1;
    return d[j-1];
  endfunction

  task automatic push(input logic [DW-1:0] d, input bit expect_out);
    fifo_mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    @(negedge clk);
    while (!(i_fifo_empty && !o_busy)) begin
      if (n >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    bit to;
    logic [DW-1:0] e;
    reset_n  = 1'b0;
    i_enable = 1'b1;
    repeat (3) @(negedge clk);
    push(8'h3C, 1'b1);
    #1;
    checks++;
    if (o_fifo_read_enable !== 1'b0 || o_txd !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rd_en=%b txd=%b busy=%b required 0 1 0", o_fifo_read_enable, o_txd, o_busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (o_fifo_read_enable !== 1'b1) begin
      errors++;
      $display("FAIL release_pop rd_en=%b required 1", o_fifo_read_enable);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b1 || o_txd !== 1'b0) begin
      errors++;
      $display("FAIL first_start busy=%b txd=%b required 1 0", o_busy, o_txd);
    end
    wait_idle(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL reset_idle_timeout got timeout required idle"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_rd >= rx_wr || rx_mem[rx_rd] !== e || !rx_ok[rx_rd]) begin
        errors++;
        $display("FAIL reset_sb got %h (frames %0d) required %h", rx_mem[rx_rd], rx_wr - rx_rd, e);
      end
      if (rx_rd < rx_wr) rx_rd++;
    end
  endtask

  task automatic test_single_byte();
    int rd0;
    logic b;
    logic [DW-1:0] e;
    bit to;
    rd0 = rd_ptr;
    push(8'h55, 1'b1);
    #1;
    checks++;
    if (o_fifo_read_enable !== 1'b1) begin
      errors++;
      $display("FAIL single_pop rd_en=%b required 1", o_fifo_read_enable);
    end
    @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      b = frame_bit(8'h55, c / CPB);
      checks++;
      if (o_txd !== b || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL single_bit cycle %0d txd=%b busy=%b required %b 1", c, o_txd, o_busy, b);
      end
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_txd !== 1'b1 || rd_ptr - rd0 != 1) begin
      errors++;
      $display("FAIL single_end busy=%b txd=%b pops=%0d required 0 1 1", o_busy, o_txd, rd_ptr - rd0);
    end
    wait_idle(50, to);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_rd >= rx_wr || rx_mem[rx_rd] !== e || !rx_ok[rx_rd]) begin
        errors++;
        $display("FAIL single_sb got %h (frames %0d) required %h", rx_mem[rx_rd], rx_wr - rx_rd, e);
      end
      if (rx_rd < rx_wr) rx_rd++;
    end
  endtask

  task automatic test_back_to_back();
    int rd0;
    logic b;
    logic [DW-1:0] e;
    bit to;
    rd0 = rd_ptr;
    push(8'hA3, 1'b1);
    push(8'h0F, 1'b1);
    @(posedge clk);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      b = (c < 40) ? frame_bit(8'hA3, c / CPB) : frame_bit(8'h0F, (c - 40) / CPB);
      checks++;
      if (o_txd !== b || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bit cycle %0d txd=%b busy=%b required %b 1", c, o_txd, o_busy, b);
      end
      if (c == 38 || c == 39) begin
        checks++;
        if (o_fifo_read_enable !== (c == 39)) begin
          errors++;
          $display("FAIL b2b_pop cycle %0d rd_en=%b required %b", c, o_fifo_read_enable, c == 39);
        end
      end
    end
    wait_idle(50, to);
    checks++;
    if (to || rd_ptr - rd0 != 2) begin
      errors++;
      $display("FAIL b2b_pops got %0d timeout=%b required 2", rd_ptr - rd0, to);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_rd >= rx_wr || rx_mem[rx_rd] !== e || !rx_ok[rx_rd]) begin
        errors++;
        $display("FAIL b2b_sb got %h (frames %0d) required %h", rx_mem[rx_rd], rx_wr - rx_rd, e);
      end
      if (rx_rd < rx_wr) rx_rd++;
    end
  endtask

  task automatic test_enable();
    int rd0;
    bit bad;
    bit to;
    logic [DW-1:0] e;
    rd0 = rd_ptr;
    i_enable = 1'b0;
    push(8'hFF, 1'b1);
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (o_txd !== 1'b1 || o_fifo_read_enable !== 1'b0 || o_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || rd_ptr != rd0) begin
      errors++;
      $display("FAIL disabled_hold activity=%b pops=%0d required 0 0", bad, rd_ptr - rd0);
    end
    i_enable = 1'b1;
    #1;
    checks++;
    if (o_fifo_read_enable !== 1'b1) begin
      errors++;
      $display("FAIL enable_pop rd_en=%b required 1", o_fifo_read_enable);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b1 || o_txd !== 1'b0) begin
      errors++;
      $display("FAIL enable_start busy=%b txd=%b required 1 0", o_busy, o_txd);
    end
    wait_idle(100, to);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_rd >= rx_wr || rx_mem[rx_rd] !== e || !rx_ok[rx_rd]) begin
        errors++;
        $display("FAIL enable_sb got %h (frames %0d) required %h", rx_mem[rx_rd], rx_wr - rx_rd, e);
      end
      if (rx_rd < rx_wr) rx_rd++;
    end
  endtask

  task automatic test_mid_disable();
    int rd0;
    int n;
    bit bad;
    bit to;
    logic [DW-1:0] e;
    rd0 = rd_ptr;
    push(8'h81, 1'b1);
    push(8'h42, 1'b1);
    @(posedge clk);
    for (int c = 0; c <= 10; c++) @(negedge clk);
    i_enable = 1'b0;
    n = 0;
    while (o_busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100 || rd_ptr - rd0 != 1 || wr_ptr - rd_ptr != 1) begin
      errors++;
      $display("FAIL middis_pops got %0d left %0d required 1 1", rd_ptr - rd0, wr_ptr - rd_ptr);
    end
    e = exp_q.pop_front();
    checks++;
    if (rx_rd >= rx_wr || rx_mem[rx_rd] !== e || !rx_ok[rx_rd]) begin
      errors++;
      $display("FAIL middis_frame got %h (frames %0d) required %h", rx_mem[rx_rd], rx_wr - rx_rd, e);
    end
    if (rx_rd < rx_wr) rx_rd++;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_txd !== 1'b1 || o_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL middis_idle activity=%b required 0", bad); end
    i_enable = 1'b1;
    wait_idle(100, to);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_rd >= rx_wr || rx_mem[rx_rd] !== e || !rx_ok[rx_rd]) begin
        errors++;
        $display("FAIL middis_sb got %h (frames %0d) required %h", rx_mem[rx_rd], rx_wr - rx_rd, e);
      end
      if (rx_rd < rx_wr) rx_rd++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int rd0;
    int rx0;
    bit bad;
    rd0 = rd_ptr;
    rx0 = rx_wr;
    push(8'h96, 1'b0);
    @(posedge clk);
    for (int c = 0; c <= 17; c++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (o_txd !== 1'b1 || o_busy !== 1'b0 || o_fifo_read_enable !== 1'b0) begin
      errors++;
      $display("FAIL abort_now txd=%b busy=%b rd_en=%b required 1 0 0", o_txd, o_busy, o_fifo_read_enable);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (o_txd !== 1'b1 || o_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || rd_ptr - rd0 != 1 || rx_wr != rx0) begin
      errors++;
      $display("FAIL abort_after activity=%b pops=%0d frames=%0d required 0 1 0", bad, rd_ptr - rd0, rx_wr - rx0);
    end
  endtask

  task automatic test_random_burst();
    int rd0;
    bit to;
    logic [DW-1:0] e;
    rd0 = rd_ptr;
    for (int i = 0; i < 64; i++) begin
      push(8'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
    end
    wait_idle(4000, to);
    checks++;
    if (to || rd_ptr - rd0 != 64 || bad_pops != 0) begin
      errors++;
      $display("FAIL burst_pops got %0d bad=%0d timeout=%b required 64 0", rd_ptr - rd0, bad_pops, to);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_rd >= rx_wr || rx_mem[rx_rd] !== e || !rx_ok[rx_rd]) begin
        errors++;
        $display("FAIL burst_sb got %h (frames %0d) required %h", rx_mem[rx_rd], rx_wr - rx_rd, e);
      end
      if (rx_rd < rx_wr) rx_rd++;
    end
    checks++;
    if (rx_rd != rx_wr) begin
      errors++;
      $display("FAIL extra_frames got %0d required 0", rx_wr - rx_rd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    i_enable = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_enable();
    test_mid_disable();
    test_reset_mid_frame();
    test_random_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
